// File: rtl/network_sequencer.sv
// Forward-pass sequencer for a chain of conv layers: shifts in a sample,
// starts each layer in turn, advances activation caches between layers,
// latches the final layer output, and tracks overrun/timeout errors.
module network_sequencer #(
  parameter int W        = 16,
  parameter int N_LAYERS = 3,
  parameter int IO_D     = 4,
  parameter int TIMEOUT  = 4095
) (
  input  logic                  sample_clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  err_clr,
  input  logic [N_LAYERS-1:0]   layer_done,
  input  logic [IO_D*W-1:0]     final_in,
  output logic                  lsb_shift,
  output logic [N_LAYERS-1:0]   layer_start,
  output logic [N_LAYERS-1:0]   cache_advance,
  output logic [IO_D*W-1:0]     sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            overrun_count,
  output logic                  timeout_err,
  output logic [2*W-1:0]        pass_cycles
);

  localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  // The last layer has no downstream cache to advance.
  localparam logic [N_LAYERS-1:0] ADV_MASK = ~(N_LAYERS'(1) << (N_LAYERS - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_START,
    S_WAIT,
    S_ADVANCE,
    S_OUTPUT
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [TW-1:0]   wait_cnt;
  logic [2*W-1:0]  cyc_cnt, cyc_sat;
  logic [7:0]      ovc_sat;
  logic            tick_rej;
  logic            to_evt;

  // Next-state and error-event decode from the current state.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    tick_rej  = 1'b0;
    to_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_tick) begin
          state_nxt = S_SHIFT;
          k_nxt     = '0;
        end
      end
      S_SHIFT: begin
        tick_rej  = sample_tick;
        state_nxt = S_START;
      end
      S_START: begin
        tick_rej  = sample_tick;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tick_rej = sample_tick;
        if (layer_done[k]) begin
          if (k == KW'(N_LAYERS - 1)) state_nxt = S_OUTPUT;
          else                         state_nxt = S_ADVANCE;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = S_IDLE;
          to_evt    = 1'b1;
        end
      end
      S_ADVANCE: begin
        tick_rej  = sample_tick;
        state_nxt = S_START;
        k_nxt     = k + 1'b1;
      end
      S_OUTPUT: begin
        if (sample_tick) begin
          state_nxt = S_SHIFT;
          k_nxt     = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Saturating increments for the pass cycle counter and overrun counter.
  always_comb begin
    cyc_sat = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
    ovc_sat = (&overrun_count) ? overrun_count : overrun_count + 1'b1;
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      k             <= '0;
      wait_cnt      <= '0;
      cyc_cnt       <= '0;
      lsb_shift     <= 1'b0;
      layer_start   <= '0;
      cache_advance <= '0;
      sample_out    <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
      timeout_err   <= 1'b0;
      pass_cycles   <= '0;
    end else begin
      state         <= state_nxt;
      k             <= k_nxt;
      lsb_shift     <= (state_nxt == S_SHIFT);
      layer_start   <= (state_nxt == S_START) ? (N_LAYERS'(1) << k_nxt) : '0;
      cache_advance <= (state_nxt == S_ADVANCE) ? ((N_LAYERS'(1) << k_nxt) & ADV_MASK) : '0;
      out_valid     <= (state_nxt == S_OUTPUT);
      busy          <= (state_nxt != S_IDLE);

      if (state_nxt == S_WAIT && state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                                        wait_cnt <= '0;

      // Count includes the SHIFT cycle, so a new pass starts at one.
      if (state_nxt == S_SHIFT)  cyc_cnt <= (2*W)'(1);
      else if (state != S_IDLE)  cyc_cnt <= cyc_sat;

      // cyc_sat already accounts for the OUTPUT cycle itself.
      if (state_nxt == S_OUTPUT) begin
        sample_out  <= final_in;
        pass_cycles <= cyc_sat;
      end

      if (tick_rej) begin
        overrun       <= 1'b1;
        overrun_count <= err_clr ? 8'd1 : ovc_sat;
      end else if (err_clr) begin
        overrun       <= 1'b0;
        overrun_count <= '0;
      end

      if (to_evt)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: cycle traces of the pulse outputs
// against a hand-built schedule, plus overrun, timeout, reset and N_LAYERS=1.
module tb_network_sequencer;

  localparam int W = 16;
  localparam int IO_D = 4;

  logic            sample_clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_tick = 1'b0;
  logic            err_clr = 1'b0;
  logic [2:0]      layer_done = '0;
  logic [63:0]     final_in = '0;
  logic            lsb_shift;
  logic [2:0]      layer_start;
  logic [2:0]      cache_advance;
  logic [63:0]     sample_out;
  logic            out_valid;
  logic            busy;
  logic            overrun;
  logic [7:0]      overrun_count;
  logic            timeout_err;
  logic [31:0]     pass_cycles;

  logic            tick1 = 1'b0;
  logic [0:0]      done1 = 1'b1;
  logic [63:0]     final1 = 64'hABCD_0123_4567_89EF;
  logic            lsb_shift1;
  logic [0:0]      layer_start1;
  logic [0:0]      cache_advance1;
  logic [63:0]     sample_out1;
  logic            out_valid1;
  logic            busy1;
  logic            overrun1;
  logic [7:0]      overrun_count1;
  logic            timeout_err1;
  logic [31:0]     pass_cycles1;

  network_sequencer #(.W(W), .N_LAYERS(3), .IO_D(IO_D), .TIMEOUT(16)) u_dut (
    .sample_clk(sample_clk), .rst(rst), .sample_tick(sample_tick), .err_clr(err_clr),
    .layer_done(layer_done), .final_in(final_in), .lsb_shift(lsb_shift),
    .layer_start(layer_start), .cache_advance(cache_advance), .sample_out(sample_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .overrun_count(overrun_count),
    .timeout_err(timeout_err), .pass_cycles(pass_cycles)
  );

  network_sequencer #(.W(W), .N_LAYERS(1), .IO_D(IO_D), .TIMEOUT(16)) u_one (
    .sample_clk(sample_clk), .rst(rst), .sample_tick(tick1), .err_clr(err_clr),
    .layer_done(done1), .final_in(final1), .lsb_shift(lsb_shift1),
    .layer_start(layer_start1), .cache_advance(cache_advance1), .sample_out(sample_out1),
    .out_valid(out_valid1), .busy(busy1), .overrun(overrun1), .overrun_count(overrun_count1),
    .timeout_err(timeout_err1), .pass_cycles(pass_cycles1)
  );

  always #5 sample_clk = ~sample_clk;

  int n_vec = 0;
  int n_err = 0;

  // Conv-unit stand-in: out_v drops on layer_start, rises after dly[j] WAIT cycles.
  int   dly[3] = '{0, 0, 0};
  logic stuck[3] = '{1'b0, 1'b0, 1'b0};
  int   rem[3] = '{0, 0, 0};
  always @(negedge sample_clk) begin
    for (int j = 0; j < 3; j++) begin
      if (layer_start[j]) begin
        rem[j] = dly[j];
        layer_done[j] = 1'b0;
      end else if (!layer_done[j] && !stuck[j]) begin
        if (rem[j] == 0) layer_done[j] = 1'b1;
        else             rem[j] = rem[j] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sample_clk);
  endtask

  // Expected per-cycle {lsb_shift, layer_start, cache_advance, out_valid, busy}.
  logic [8:0] exp_tr[64];
  logic [8:0] obs_tr[64];
  logic       obs_te[64];
  int         exp_len;

  task automatic add_pass(input int w0, input int w1, input int w2, input int abort_layer);
    int wl[3];
    wl[0] = w0; wl[1] = w1; wl[2] = w2;
    exp_len++; exp_tr[exp_len] = 9'b1_000_000_0_1;
    for (int j = 0; j < 3; j++) begin
      exp_len++; exp_tr[exp_len] = {1'b0, 3'(1 << j), 3'b000, 1'b0, 1'b1};
      for (int i = 0; i < wl[j]; i++) begin
        exp_len++; exp_tr[exp_len] = 9'b0_000_000_0_1;
      end
      if (j == abort_layer) return;
      exp_len++;
      if (j < 2) exp_tr[exp_len] = {1'b0, 3'b000, 3'(1 << j), 1'b0, 1'b1};
      else       exp_tr[exp_len] = 9'b0_000_000_1_1;
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_len++; exp_tr[exp_len] = 9'b0;
    end
  endtask

  // Tick in cycle 0 (the current negedge), optional extra ticks at t0/t1,
  // then compare the recorded trace with the expected schedule.
  task automatic run(input string name, input int ncyc, input int t0, input int t1);
    sample_tick = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      obs_tr[c] = {lsb_shift, layer_start, cache_advance, out_valid, busy};
      obs_te[c] = timeout_err;
      sample_tick = (c == t0) || (c == t1);
    end
    sample_tick = 1'b0;
    for (int c = 1; c <= ncyc; c++)
      chk($sformatf("%s.c%0d", name, c), 64'(obs_tr[c]), 64'(exp_tr[c]));
  endtask

  localparam logic [63:0] F1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] F2 = 64'h5555_6666_7777_8888;

  initial begin
    step(); step();
    chk("reset_outputs", 64'({lsb_shift, layer_start, cache_advance, out_valid, busy,
                              overrun, timeout_err}), 64'h0);
    chk("reset_sample_out", sample_out, 64'h0);
    chk("reset_pass_cycles", 64'(pass_cycles), 64'h0);
    rst = 1'b0;
    step(); step();

    // Nominal pass: every layer done in its first WAIT cycle.
    final_in = F1;
    exp_len = 0; add_pass(1, 1, 1, -1); add_idle(1);
    run("nominal", 11, -1, -1);
    chk("nominal_sample_out", sample_out, F1);
    chk("nominal_pass_cycles", 64'(pass_cycles), 64'd10);
    chk("nominal_flags", 64'({overrun, timeout_err}), 64'h0);
    step();

    // Layer 1 done five WAIT cycles late.
    dly[1] = 5;
    exp_len = 0; add_pass(1, 6, 1, -1); add_idle(1);
    run("delayed", 16, -1, -1);
    chk("delayed_pass_cycles", 64'(pass_cycles), 64'd15);
    chk("delayed_flags", 64'({overrun, timeout_err}), 64'h0);
    dly[1] = 0;
    step();

    // Tick in ADVANCE (cycle 4) is rejected; tick in OUTPUT restarts.
    exp_len = 0; add_pass(1, 1, 1, -1); add_pass(1, 1, 1, -1); add_idle(1);
    run("overrun", 21, 4, 10);
    chk("overrun_flag", 64'(overrun), 64'd1);
    chk("overrun_count", 64'(overrun_count), 64'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("overrun_clr", 64'({overrun, overrun_count}), 64'h0);
    step();

    // Layer 0 never completes: timeout after 16 WAIT cycles.
    final_in = F2;
    stuck[0] = 1'b1;
    exp_len = 0; add_pass(16, 0, 0, 0); add_idle(2);
    run("timeout", 20, -1, -1);
    chk("timeout_c18", 64'(obs_te[18]), 64'd0);
    chk("timeout_c19", 64'(obs_te[19]), 64'd1);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_hold_out", sample_out, F1);
    chk("timeout_hold_cycles", 64'(pass_cycles), 64'd10);
    stuck[0] = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("timeout_clr", 64'(timeout_err), 64'd0);
    step();

    // Reset during WAIT of layer 2, with an overrun already recorded.
    dly[2] = 3;
    sample_tick = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      sample_tick = (c == 3);
    end
    chk("prereset_state", 64'({busy, overrun}), 64'h3);
    rst = 1'b1;
    #1;
    chk("midreset_pulses", 64'({lsb_shift, layer_start, cache_advance, out_valid, busy}), 64'h0);
    chk("midreset_flags", 64'({overrun, overrun_count, timeout_err}), 64'h0);
    chk("midreset_sample_out", sample_out, 64'h0);
    chk("midreset_pass_cycles", 64'(pass_cycles), 64'h0);
    step(); rst = 1'b0;
    dly[2] = 0;
    step();
    chk("release_no_pulse", 64'({lsb_shift, layer_start, cache_advance, out_valid, busy}), 64'h0);
    exp_len = 0; add_pass(1, 1, 1, -1); add_idle(1);
    run("postreset", 11, -1, -1);
    chk("postreset_pass_cycles", 64'(pass_cycles), 64'd10);
    chk("postreset_sample_out", sample_out, F2);
    step();

    // Single-layer instance.
    tick1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      tick1 = 1'b0;
      chk($sformatf("one_adv.c%0d", c), 64'(cache_advance1), 64'd0);
      chk($sformatf("one_valid.c%0d", c), 64'(out_valid1), 64'(c == 4));
    end
    chk("one_pass_cycles", 64'(pass_cycles1), 64'd4);
    chk("one_sample_out", sample_out1, final1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, sample element width in bits.
REQ-002 SHALL have parameter N_LAYERS, default 3, number of chained conv layers (legal 1..8).
REQ-003 SHALL have parameter IO_D, default 4, channel count of final layer output.
REQ-004 SHALL have parameter TIMEOUT, default 4095, maximum WAIT cycles per layer.
REQ-005 SHALL have port sample_clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sample_tick  in  1  one-cycle request to start a forward pass.
REQ-008 SHALL have port err_clr  in  1  synchronous clear of sticky error state.
REQ-009 SHALL have port layer_done  in  N_LAYERS  per-layer out_v level from conv units.
REQ-010 SHALL have port final_in  in  IO_D*W  packed output of last conv layer.
REQ-011 SHALL have port lsb_shift  out  1  pulse advancing input left shift buffers.
REQ-012 SHALL have port layer_start  out  N_LAYERS  one-hot pulse resetting/starting conv k.
REQ-013 SHALL have port cache_advance  out  N_LAYERS  pulse clocking activation cache after layer k; bit N_LAYERS-1 always 0.
REQ-014 SHALL have port sample_out  out  IO_D*W  registered network output.
REQ-015 SHALL have port out_valid  out  1  pulse when sample_out updates.
REQ-016 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-017 SHALL have port overrun  out  1  sticky: tick rejected while busy.
REQ-018 SHALL have port overrun_count  out  8  saturating count of rejected ticks.
REQ-019 SHALL have port timeout_err  out  1  sticky: layer failed to complete.
REQ-020 SHALL have port pass_cycles  out  2*W  cycle count of last completed pass.

Function
REQ-021 SHALL implement states IDLE, SHIFT, START, WAIT, ADVANCE, OUTPUT plus layer index k (0..N_LAYERS-1).
REQ-022 SHALL move IDLE->SHIFT on sample_tick=1; k<=0.
REQ-023 SHALL move SHIFT->START unconditionally.
REQ-024 SHALL move START->WAIT unconditionally; layer_done[k] ignored during START.
REQ-025 SHALL move WAIT->ADVANCE when layer_done[k]=1 and k<N_LAYERS-1; WAIT->OUTPUT when layer_done[k]=1 and k=N_LAYERS-1.
REQ-026 SHALL move ADVANCE->START with k<=k+1.
REQ-027 SHALL move OUTPUT->IDLE, or OUTPUT->SHIFT (k<=0) if sample_tick=1 in that cycle; not an overrun.
REQ-028 SHALL decode outputs from current state (Moore): lsb_shift=1 in SHIFT; layer_start[k]=1 in START; cache_advance[k]=1 in ADVANCE; out_valid=1 in OUTPUT; all other bits 0.
REQ-029 SHALL load sample_out<=final_in at the OUTPUT clock edge; hold otherwise.
REQ-030 SHALL achieve minimum latency: out_valid high 3*N_LAYERS+1 cycles after the edge sampling sample_tick (10 for N_LAYERS=3) when each layer_done is high in its first WAIT cycle.
REQ-031 SHALL count cycles from SHIFT through OUTPUT inclusive, saturating at 2^(2W)-1, and load pass_cycles at OUTPUT (minimum 3*N_LAYERS+1).
REQ-032 SHALL, on sample_tick=1 in any state except IDLE/OUTPUT, ignore the tick, set overrun, increment overrun_count saturating at 255.
REQ-033 SHALL, after TIMEOUT consecutive WAIT cycles without layer_done[k], set timeout_err and go to IDLE with no out_valid, sample_out and pass_cycles unchanged.
REQ-034 SHALL, on err_clr=1, clear overrun, overrun_count, timeout_err; a same-cycle set event wins over err_clr.
REQ-035 SHALL not interrupt a pass on err_clr.

Reset
REQ-036 SHALL on rst=1 force state IDLE, k=0, all outputs 0 (sample_out, pass_cycles, counters, flags) immediately, including mid-pass; no pulse output SHALL be emitted in the first cycle after release.

Verification
REQ-037 N_LAYERS=3, done returned in first WAIT cycle, tick once -> lsb_shift cycle 1, layer_start 001/010/100 at cycles 2/5/8, cache_advance 001/010 at 4/7, out_valid cycle 10, sample_out=final_in, pass_cycles=10.
REQ-038 Layer 1 done delayed 5 WAIT cycles -> out_valid cycle 15, pass_cycles=15, no errors.
REQ-039 Tick at cycle 4 of a pass, and tick during OUTPUT -> overrun=1, overrun_count=1; OUTPUT-cycle tick starts new pass with lsb_shift next cycle.
REQ-040 TIMEOUT=16, layer_done[0] stuck low -> timeout_err=1 after 16 WAIT cycles, busy=0, out_valid never asserted, sample_out holds previous value; err_clr -> timeout_err=0.
REQ-041 rst asserted during WAIT of layer 2 -> all outputs 0 same cycle; next tick after release yields full normal pass, pass_cycles=10.
REQ-042 N_LAYERS=1 -> cache_advance never asserted, out_valid cycle 4, pass_cycles=4.
